kpn_queue_fifo: RTL and testbench
=================================

Name: kpn_queue_fifo

Overview:
Parametrised KPN channel FIFO and next generation of the team's queue block.
- Adds synchronous reset, full/empty/occupancy outputs and well-defined simultaneous read/write behaviour.
- Adds a reset-driven precharge sequencer that loads initial tokens from a parameter instead of a file.
- Sits between a producer and a consumer process node; one instance per channel.

Parameters:
DATA_WIDTH, 16, token width in bits.
ADDR_BITS, 5, pointer width; depth = 2**ADDR_BITS (32).
PRECHARGE_COUNT, 0, initial tokens loaded after reset; legal range 0..2**ADDR_BITS.
PRECHARGE_DATA, 0, packed vector of width DATA_WIDTH*max(PRECHARGE_COUNT,1). Token i = bits [i*DATA_WIDTH +: DATA_WIDTH]. Token 0 is read first.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
wr  in  1  write request from producer.
entry_1  in  DATA_WIDTH  write token.
rd  in  1  read request (pop) from consumer.
output_1  out  DATA_WIDTH  head token, first-word-fall-through.
full  out  1  queue holds 2**ADDR_BITS tokens.
empty  out  1  queue holds 0 tokens.
count  out  ADDR_BITS+1  current occupancy.
ready  out  1  precharge finished; queue accepts writes.

Behaviour:
- Reset values, taking effect at the clk edge where reset=1:
  - w_ptr=0, r_ptr=0, count=0, full=0, empty=1.
  - ready=0, FSM state=PRECHARGE.
  - output_1 undefined while empty.
  - Memory contents are not cleared.
- FSM PRECHARGE:
  - Each cycle writes token k (k=0,1,...) at w_ptr, then w_ptr+1 and count+1.
  - External wr is ignored.
  - rd is honoured once count>0, i.e. precharge tokens are readable immediately.
  - Goes to RUN after the cycle that writes token PRECHARGE_COUNT-1.
- FSM RUN:
  - Entered directly one cycle after reset deasserts when PRECHARGE_COUNT=0.
  - ready=1; it is registered and asserts in the cycle after the last precharge write.
- Write: accepted when state=RUN and wr=1 and (full=0 or rd accepted in the same cycle).
  - Stores entry_1 at w_ptr; w_ptr wraps modulo 2**ADDR_BITS.
- Read: accepted when rd=1 and empty=0.
  - r_ptr+1 with wrap.
  - output_1 = mem[r_ptr], combinational from the registered pointer; a new head is visible the cycle after the pop.
- Simultaneous accepted read and write:
  - count unchanged; full and empty unchanged.
  - Writing while full is legal only because a read is accepted in the same cycle.
- rd on empty and wr on full (no read): ignored; no pointer, count or flag change.
- rd=1, wr=1 with empty=1: write accepted, read ignored; count becomes 1.
- Flags are derived from count (full = count==2**ADDR_BITS, empty = count==0), registered, and consistent with count in every cycle.
- Reset asserted mid-precharge or mid-operation:
  - Aborts immediately; all state returns to reset values.
  - Precharge restarts from token 0 after reset deasserts.
- PRECHARGE_COUNT greater than depth is illegal; an elaboration-time check fails the build.

Optional Feature:
Macro KPN_QUEUE_ERR_EN.
- Defined: adds outputs overflow_err (1) and underflow_err (1), plus drop_cnt (16).
  - overflow_err sets on a rejected write: wr=1 in RUN while full with no accepted read.
  - underflow_err sets on rd=1 while empty.
  - Both flags are sticky until reset.
  - drop_cnt counts rejected writes, saturating at 16'hFFFF.
  - wr during PRECHARGE is not counted as a rejected write.
- Not defined: ports and logic are absent; rejected operations are silently ignored as above.

Test Plan:
1. PRECHARGE_COUNT=2, PRECHARGE_DATA={16'd1,16'd0}. Reset 1 cycle, then idle.
   -> ready rises 3 cycles after reset deasserts; count=2. Pop twice -> output_1 reads 0 then 1; empty=1 afterwards.
2. PRECHARGE_COUNT=0. Write 32 tokens 0x0100..0x011F.
   -> full=1, count=32. 33rd write 0xDEAD is ignored; popping 32 tokens returns 0x0100..0x011F in order.
3. Fill to full, then rd=1 and wr=1 with 0xBEEF for 1 cycle.
   -> count stays 32, full stays 1. Head advances; 0xBEEF is returned as the 32nd pop.
4. Empty queue, rd=1 and wr=1 with 0x00AA.
   -> count=1, empty=0; output_1=0x00AA next cycle. Then rd only -> empty=1.
5. Wrap-around: 40 cycles of write-then-read of incrementing values.
   -> every pop equals its write; count never exceeds 1; pointers wrap past 31 with no corruption.
6. PRECHARGE_COUNT=4, reset re-asserted after 2 precharge cycles.
   -> count=0, ready=0. After release, tokens 0..3 are reloaded and count=4.
   With KPN_QUEUE_ERR_EN: wr during precharge leaves drop_cnt at 0.

Source files
------------

// File: rtl/kpn_queue_fifo_if.sv
// rtl/kpn_queue_fifo_if.sv - producer/consumer handshake bundle for kpn_queue_fifo (KPN_QUEUE_ERR_EN adds error status)
interface kpn_queue_fifo_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_BITS  = 5
);
    logic                  wr;
    logic [DATA_WIDTH-1:0] entry_1;
    logic                  rd;
    logic [DATA_WIDTH-1:0] output_1;
    logic                  full;
    logic                  empty;
    logic [ADDR_BITS:0]    count;
    logic                  ready;
`ifdef KPN_QUEUE_ERR_EN
    logic                  overflow_err;
    logic                  underflow_err;
    logic [15:0]           drop_cnt;

    modport master (
        output wr, entry_1, rd,
        input  output_1, full, empty, count, ready, overflow_err, underflow_err, drop_cnt
    );
    modport slave (
        input  wr, entry_1, rd,
        output output_1, full, empty, count, ready, overflow_err, underflow_err, drop_cnt
    );
`else
    modport master (
        output wr, entry_1, rd,
        input  output_1, full, empty, count, ready
    );
    modport slave (
        input  wr, entry_1, rd,
        output output_1, full, empty, count, ready
    );
`endif
endinterface

// File: rtl/kpn_queue_fifo.sv
// rtl/kpn_queue_fifo.sv - KPN channel FIFO with reset-driven precharge (KPN_QUEUE_ERR_EN adds error status)
module kpn_queue_fifo #(
    parameter int DATA_WIDTH      = 16,
    parameter int ADDR_BITS       = 5,
    parameter int PRECHARGE_COUNT = 0,
    parameter logic [DATA_WIDTH*((PRECHARGE_COUNT > 0) ? PRECHARGE_COUNT : 1)-1:0] PRECHARGE_DATA = '0
) (
    input logic              clk,
    input logic              reset,
    kpn_queue_fifo_if.slave  q
);
    localparam int                 DEPTH   = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0] PRE_C   = (ADDR_BITS+1)'(PRECHARGE_COUNT);

    generate
        if (PRECHARGE_COUNT < 0 || PRECHARGE_COUNT > DEPTH) begin : g_bad_precharge
            $error("kpn_queue_fifo: PRECHARGE_COUNT out of range 0..2**ADDR_BITS");
        end
    endgenerate

    typedef enum logic {S_PRECHARGE, S_RUN} state_t;

    // Precharge tokens laid out as a depth-sized table so the index never leaves range.
    logic [DATA_WIDTH-1:0] pre_rom [DEPTH];
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        if (i < PRECHARGE_COUNT) begin : g_tok
            assign pre_rom[i] = PRECHARGE_DATA[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_pad
            assign pre_rom[i] = '0;
        end
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    state_t                state;
    logic [ADDR_BITS-1:0]  w_ptr, r_ptr;
    logic [ADDR_BITS:0]    pre_idx, count_r, count_next;
    logic                  full_r, empty_r, ready_r;
    logic                  rd_ok, pre_wr, run_wr, do_wr;
    logic [DATA_WIDTH-1:0] wdata;

    always_comb begin
        rd_ok  = q.rd && !empty_r;
        pre_wr = (state == S_PRECHARGE) && (pre_idx != PRE_C);
        run_wr = (state == S_RUN) && q.wr && (!full_r || rd_ok);
        do_wr  = pre_wr || run_wr;
        wdata  = pre_wr ? pre_rom[pre_idx[ADDR_BITS-1:0]] : q.entry_1;
        count_next = count_r;
        case ({do_wr, rd_ok})
            2'b10:   count_next = count_r + 1'b1;
            2'b01:   count_next = count_r - 1'b1;
            default: count_next = count_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_PRECHARGE;
            w_ptr   <= '0;
            r_ptr   <= '0;
            pre_idx <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            ready_r <= 1'b0;
        end else begin
            if (do_wr) w_ptr <= w_ptr + 1'b1;
            if (rd_ok) r_ptr <= r_ptr + 1'b1;
            count_r <= count_next;
            full_r  <= (count_next == DEPTH_C);
            empty_r <= (count_next == '0);
            case (state)
                S_PRECHARGE: begin
                    if (pre_idx == PRE_C) begin
                        state   <= S_RUN;
                        ready_r <= 1'b1;
                    end else begin
                        pre_idx <= pre_idx + 1'b1;
                    end
                end
                default: ready_r <= 1'b1;
            endcase
        end
    end

    // Storage is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && do_wr) mem[w_ptr] <= wdata;
    end

    assign q.output_1 = mem[r_ptr];
    assign q.full     = full_r;
    assign q.empty    = empty_r;
    assign q.count    = count_r;
    assign q.ready    = ready_r;

`ifdef KPN_QUEUE_ERR_EN
    logic        overflow_r, underflow_r, rej_wr;
    logic [15:0] drop_r;

    assign rej_wr = (state == S_RUN) && q.wr && full_r && !rd_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            drop_r      <= '0;
        end else begin
            if (rej_wr) begin
                overflow_r <= 1'b1;
                if (drop_r != 16'hFFFF) drop_r <= drop_r + 1'b1;
            end
            if (q.rd && empty_r) underflow_r <= 1'b1;
        end
    end

    assign q.overflow_err  = overflow_r;
    assign q.underflow_err = underflow_r;
    assign q.drop_cnt      = drop_r;
`endif
endmodule

// File: tb/tb_kpn_queue_fifo.sv
// tb/tb_kpn_queue_fifo.sv - self-checking bench for kpn_queue_fifo (KPN_QUEUE_ERR_EN checks error status)
module tb_kpn_queue_fifo;
    logic clk;
    logic rst_a, rst_b, rst_c;
    int   total, bad, drops;
    logic [15:0] mq[$];

    kpn_queue_fifo_if #(.DATA_WIDTH(16), .ADDR_BITS(5)) ifa ();
    kpn_queue_fifo_if #(.DATA_WIDTH(16), .ADDR_BITS(5)) ifb ();
    kpn_queue_fifo_if #(.DATA_WIDTH(16), .ADDR_BITS(5)) ifc ();

    kpn_queue_fifo #(.DATA_WIDTH(16), .ADDR_BITS(5), .PRECHARGE_COUNT(0)) dut_a (
        .clk(clk), .reset(rst_a), .q(ifa.slave));
    kpn_queue_fifo #(.DATA_WIDTH(16), .ADDR_BITS(5), .PRECHARGE_COUNT(2),
        .PRECHARGE_DATA({16'd1, 16'd0})) dut_b (
        .clk(clk), .reset(rst_b), .q(ifb.slave));
    kpn_queue_fifo #(.DATA_WIDTH(16), .ADDR_BITS(5), .PRECHARGE_COUNT(4),
        .PRECHARGE_DATA({16'h0D03, 16'h0C02, 16'h0B01, 16'h0A00})) dut_c (
        .clk(clk), .reset(rst_c), .q(ifc.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] data;
        int          count;
        logic        empty;
        logic        full;
        logic [15:0] head;
    } vec_t;
    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue-level reference: pop if anything is there, push if room (or a pop frees it).
    task automatic cyc_a(input logic w, input logic r, input logic [15:0] d);
        logic rd_ok, wr_ok;
        ifa.wr = w; ifa.rd = r; ifa.entry_1 = d;
        rd_ok = r && (mq.size() > 0);
        wr_ok = w && ((mq.size() < 32) || rd_ok);
        if (w && !wr_ok) drops++;
        if (rd_ok) void'(mq.pop_front());
        if (wr_ok) mq.push_back(d);
        step();
        ifa.wr = 1'b0; ifa.rd = 1'b0;
        chk("a_count", 32'(ifa.count), mq.size());
        chk("a_full", 32'(ifa.full), 32'(mq.size() == 32));
        chk("a_empty", 32'(ifa.empty), 32'(mq.size() == 0));
        if (mq.size() > 0) chk("a_head", 32'(ifa.output_1), 32'(mq[0]));
    endtask

    initial begin
        vt[0] = '{1'b0, 1'b1, 16'h0000, 0, 1'b1, 1'b0, 16'h0000};
        vt[1] = '{1'b1, 1'b0, 16'h1111, 1, 1'b0, 1'b0, 16'h1111};
        vt[2] = '{1'b1, 1'b0, 16'h2222, 2, 1'b0, 1'b0, 16'h1111};
        vt[3] = '{1'b1, 1'b1, 16'h3333, 2, 1'b0, 1'b0, 16'h2222};
        vt[4] = '{1'b0, 1'b1, 16'h0000, 1, 1'b0, 1'b0, 16'h3333};
        vt[5] = '{1'b1, 1'b1, 16'h4444, 1, 1'b0, 1'b0, 16'h4444};
        vt[6] = '{1'b0, 1'b1, 16'h0000, 0, 1'b1, 1'b0, 16'h0000};
        vt[7] = '{1'b1, 1'b1, 16'h5555, 1, 1'b0, 1'b0, 16'h5555};
        vt[8] = '{1'b0, 1'b0, 16'h0000, 1, 1'b0, 1'b0, 16'h5555};
        vt[9] = '{1'b0, 1'b1, 16'h0000, 0, 1'b1, 1'b0, 16'h0000};

        total = 0; bad = 0; drops = 0;
        clk = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        ifa.wr = 0; ifa.rd = 0; ifa.entry_1 = '0;
        ifb.wr = 0; ifb.rd = 0; ifb.entry_1 = '0;
        ifc.wr = 0; ifc.rd = 0; ifc.entry_1 = '0;
        step(); step();

        chk("rst_a_count", 32'(ifa.count), 0);
        chk("rst_a_empty", 32'(ifa.empty), 1);
        chk("rst_a_full", 32'(ifa.full), 0);
        chk("rst_a_ready", 32'(ifa.ready), 0);
        chk("rst_b_ready", 32'(ifb.ready), 0);
        chk("rst_c_empty", 32'(ifc.empty), 1);

        // No precharge: RUN one cycle after reset release.
        rst_a = 1'b0;
        step();
        chk("a_ready_run", 32'(ifa.ready), 1);
        chk("a_count_run", 32'(ifa.count), 0);

        for (int i = 0; i < 10; i++) begin
            ifa.wr = vt[i].wr; ifa.rd = vt[i].rd; ifa.entry_1 = vt[i].data;
            step();
            ifa.wr = 1'b0; ifa.rd = 1'b0;
            chk($sformatf("vec%0d_count", i), 32'(ifa.count), vt[i].count);
            chk($sformatf("vec%0d_empty", i), 32'(ifa.empty), 32'(vt[i].empty));
            chk($sformatf("vec%0d_full", i), 32'(ifa.full), 32'(vt[i].full));
            if (vt[i].count > 0) chk($sformatf("vec%0d_head", i), 32'(ifa.output_1), 32'(vt[i].head));
        end

        // Fill to full, overflow attempt, drain in order.
        for (int i = 0; i < 32; i++) cyc_a(1'b1, 1'b0, 16'(16'h0100 + i));
        chk("t2_full", 32'(ifa.full), 1);
        chk("t2_count", 32'(ifa.count), 32);
        cyc_a(1'b1, 1'b0, 16'hDEAD);
        for (int i = 0; i < 32; i++) begin
            chk("t2_order", 32'(ifa.output_1), 32'(16'h0100 + i));
            cyc_a(1'b0, 1'b1, 16'h0);
        end

        // Simultaneous read/write while full.
        for (int i = 0; i < 32; i++) cyc_a(1'b1, 1'b0, 16'(16'h0200 + i));
        cyc_a(1'b1, 1'b1, 16'hBEEF);
        chk("t3_count", 32'(ifa.count), 32);
        chk("t3_full", 32'(ifa.full), 1);
        for (int i = 0; i < 32; i++) begin
            if (i == 31) chk("t3_beef_last", 32'(ifa.output_1), 32'(16'hBEEF));
            cyc_a(1'b0, 1'b1, 16'h0);
        end

        // Simultaneous read/write while empty.
        cyc_a(1'b1, 1'b1, 16'h00AA);
        chk("t4_head", 32'(ifa.output_1), 32'(16'h00AA));
        chk("t4_count", 32'(ifa.count), 1);
        cyc_a(1'b0, 1'b1, 16'h0);
        chk("t4_empty", 32'(ifa.empty), 1);

        // Pointer wrap with single-token occupancy.
        for (int i = 0; i < 40; i++) begin
            cyc_a(1'b1, 1'b0, 16'(16'h0300 + i));
            chk("t5_head", 32'(ifa.output_1), 32'(16'h0300 + i));
            cyc_a(1'b0, 1'b1, 16'h0);
        end

        // Random traffic, biased toward filling then draining.
        for (int i = 0; i < 600; i++) begin
            logic w, r;
            if (i < 300) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            cyc_a(w, r, 16'($urandom));
        end
        for (int i = 0; i < 34; i++) cyc_a(1'b0, 1'b1, 16'h0);
`ifdef KPN_QUEUE_ERR_EN
        chk("a_overflow_err", 32'(ifa.overflow_err), 1);
        chk("a_underflow_err", 32'(ifa.underflow_err), 1);
        chk("a_drop_cnt", 32'(ifa.drop_cnt), (drops > 65535) ? 65535 : drops);
`endif

        // Precharge of two tokens.
        rst_b = 1'b0;
        step();
        chk("t1_c1_count", 32'(ifb.count), 1);
        chk("t1_c1_ready", 32'(ifb.ready), 0);
        chk("t1_c1_head", 32'(ifb.output_1), 0);
        step();
        chk("t1_c2_count", 32'(ifb.count), 2);
        chk("t1_c2_ready", 32'(ifb.ready), 0);
        step();
        chk("t1_c3_ready", 32'(ifb.ready), 1);
        chk("t1_c3_count", 32'(ifb.count), 2);
        chk("t1_head0", 32'(ifb.output_1), 0);
        ifb.rd = 1'b1;
        step();
        chk("t1_head1", 32'(ifb.output_1), 1);
        chk("t1_count1", 32'(ifb.count), 1);
        step();
        ifb.rd = 1'b0;
        chk("t1_empty", 32'(ifb.empty), 1);
        chk("t1_count0", 32'(ifb.count), 0);

        // Reset during precharge restarts from token 0.
        rst_c = 1'b0;
        ifc.wr = 1'b1; ifc.entry_1 = 16'h7777;
        step(); step();
        chk("t6_mid_count", 32'(ifc.count), 2);
        rst_c = 1'b1;
        step();
        chk("t6_rst_count", 32'(ifc.count), 0);
        chk("t6_rst_ready", 32'(ifc.ready), 0);
        chk("t6_rst_empty", 32'(ifc.empty), 1);
        rst_c = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("t6_count4", 32'(ifc.count), 4);
        chk("t6_ready_lo", 32'(ifc.ready), 0);
        step();
        ifc.wr = 1'b0;
        chk("t6_ready_hi", 32'(ifc.ready), 1);
        chk("t6_count_run", 32'(ifc.count), 4);
`ifdef KPN_QUEUE_ERR_EN
        chk("t6_drop_cnt", 32'(ifc.drop_cnt), 0);
        chk("t6_overflow_err", 32'(ifc.overflow_err), 0);
`endif
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6_tok%0d", i), 32'(ifc.output_1), 32'(16'h0A00 + 16'h0101 * i));
            ifc.rd = 1'b1;
            step();
            ifc.rd = 1'b0;
        end
        chk("t6_empty", 32'(ifc.empty), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
